// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic                   ChipEnable  = 1'b1;
    localparam logic                   ChipDisable = 1'b0;
    localparam logic [InstAddrBus-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic [InstBus-1:0]     NopInst     = 32'h0000_0013;

    typedef enum logic {
        FetchBoot = 1'b0,
        FetchRun  = 1'b1
    } fetch_state_e;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or insert a bubble.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   bubble_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o,
    output logic                   id_valid_o
);

    logic [InstAddrBus-1:0] id_pc_q, id_pc_d;
    logic [InstBus-1:0]     id_inst_q, id_inst_d;
    logic                   id_valid_q, id_valid_d;

    // Bubble wins over load; neither means hold.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (bubble_i) begin
            id_pc_d    = ZeroWord;
            id_inst_d  = NopInst;
            id_valid_d = 1'b0;
        end else if (load_i) begin
            id_pc_d    = pc_i;
            id_inst_d  = inst_i;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q    <= ZeroWord;
            id_inst_q  <= NopInst;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, boot FSM, deferred-branch capture and the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] new_pc_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_inst_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o,
    output logic                   id_valid_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   pend_q, pend_d;
    logic [InstAddrBus-1:0] pend_tgt_q, pend_tgt_d;
    logic                   id_load, id_bubble;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        id_load    = 1'b0;
        id_bubble  = 1'b0;
        unique case (state_q)
            FetchBoot: state_d = FetchRun;
            FetchRun: begin
                if (flush_i) begin
                    pc_d      = word_align(new_pc_i);
                    id_bubble = 1'b1;
                    pend_d    = 1'b0;
                end else if (stall_i) begin
                    // Remember a branch resolved during the stall; replay it on release.
                    if (branch_flag_i) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = word_align(branch_target_i);
                    end
                end else if (pend_q) begin
                    pc_d      = pend_tgt_q;
                    id_bubble = 1'b1;
                    pend_d    = 1'b0;
                end else if (branch_flag_i) begin
                    pc_d      = word_align(branch_target_i);
                    id_bubble = 1'b1;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    id_load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FetchBoot;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign rom_ce_o   = (state_q == FetchRun) ? ChipEnable : ChipDisable;
    assign rom_addr_o = pc_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (id_load),
        .bubble_i   (id_bubble),
        .pc_i       (pc_q),
        .inst_i     (rom_inst_i),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, random traffic against a behavioural model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, branch_flag_i;
    logic [31:0] new_pc_i, branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o, rom_inst_i;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_run;
    logic [31:0] m_pc, m_tgt, m_id_pc, m_id_inst;
    bit          m_pend, m_id_valid;

    typedef struct {
        logic        s;
        logic        f;
        logic [31:0] np;
        logic        b;
        logic [31:0] bt;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic        v;
    } vec_t;

    vec_t tbl [21];

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0200_0193;
            32'h4:   return 32'h0400_0213;
            32'h8:   return 32'h0211_8193;
            default: return {~a[15:0], a[15:0]};
        endcase
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0;
        m_id_pc = 32'h0; m_id_inst = 32'h13; m_id_valid = 0;
    endtask

    task automatic model_bubble();
        m_id_pc = 32'h0; m_id_inst = 32'h13; m_id_valid = 0;
    endtask

    // One rising edge of the fetch stage, straight from the priority rules.
    task automatic model_edge();
        if (!m_run) begin
            m_run = 1;
        end else if (flush_i) begin
            m_pc = {new_pc_i[31:2], 2'b00}; m_pend = 0; model_bubble();
        end else if (stall_i) begin
            if (branch_flag_i) begin
                m_pend = 1; m_tgt = {branch_target_i[31:2], 2'b00};
            end
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 0; model_bubble();
        end else if (branch_flag_i) begin
            m_pc = {branch_target_i[31:2], 2'b00}; model_bubble();
        end else begin
            m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic s, input logic f, input logic [31:0] np,
                        input logic b, input logic [31:0] bt);
        stall_i = s; flush_i = f; new_pc_i = np; branch_flag_i = b; branch_target_i = bt;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ce"}, {31'b0, rom_ce_o}, {31'b0, m_run});
        chk({tag, ".addr"}, rom_addr_o, m_pc);
        chk({tag, ".id_pc"}, id_pc_o, m_id_pc);
        chk({tag, ".id_inst"}, id_inst_o, m_id_inst);
        chk({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, m_id_valid});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".ce"}, {31'b0, rom_ce_o}, 32'h0);
        chk({tag, ".addr"}, rom_addr_o, 32'h0);
        chk({tag, ".id_pc"}, id_pc_o, 32'h0);
        chk({tag, ".id_inst"}, id_inst_o, 32'h13);
        chk({tag, ".id_valid"}, {31'b0, id_valid_o}, 32'h0);
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic s, f, b;
            logic [31:0] np, bt;
            s  = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 9) == 0);
            b  = ($urandom_range(0, 9) < 2);
            np = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) == 0) bt = 32'hFFFF_FFFC;
            step(s, f, np, b, bt);
            check_model("rand");
        end
    endtask

    initial begin
        // s, f, new_pc, br, target, exp addr, exp id_pc, exp valid
        tbl[0]  = '{0, 0, 32'h0,   0, 32'h0,         32'h0,         32'h0,         0};
        tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,         32'h4,         32'h0,         1};
        tbl[2]  = '{0, 0, 32'h0,   0, 32'h0,         32'h8,         32'h4,         1};
        tbl[3]  = '{0, 0, 32'h0,   1, 32'h40,        32'h40,        32'h0,         0};
        tbl[4]  = '{0, 0, 32'h0,   0, 32'h0,         32'h44,        32'h40,        1};
        tbl[5]  = '{0, 0, 32'h0,   1, 32'hC,         32'hC,         32'h0,         0};
        tbl[6]  = '{0, 0, 32'h0,   0, 32'h0,         32'h10,        32'hC,         1};
        tbl[7]  = '{1, 0, 32'h0,   0, 32'h0,         32'h10,        32'hC,         1};
        tbl[8]  = '{1, 0, 32'h0,   1, 32'h80,        32'h10,        32'hC,         1};
        tbl[9]  = '{1, 0, 32'h0,   0, 32'h0,         32'h10,        32'hC,         1};
        tbl[10] = '{0, 0, 32'h0,   0, 32'h0,         32'h80,        32'h0,         0};
        tbl[11] = '{0, 0, 32'h0,   0, 32'h0,         32'h84,        32'h80,        1};
        tbl[12] = '{1, 0, 32'h0,   1, 32'h300,       32'h84,        32'h80,        1};
        tbl[13] = '{1, 1, 32'h203, 0, 32'h0,         32'h200,       32'h0,         0};
        tbl[14] = '{0, 0, 32'h0,   0, 32'h0,         32'h204,       32'h200,       1};
        tbl[15] = '{1, 0, 32'h0,   1, 32'h500,       32'h204,       32'h200,       1};
        tbl[16] = '{0, 0, 32'h0,   1, 32'h600,       32'h500,       32'h0,         0};
        tbl[17] = '{0, 0, 32'h0,   0, 32'h0,         32'h504,       32'h500,       1};
        tbl[18] = '{0, 0, 32'h0,   1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         0};
        tbl[19] = '{0, 0, 32'h0,   0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1};
        tbl[20] = '{0, 0, 32'h0,   0, 32'h0,         32'h4,         32'h0,         1};

        rst_n = 1'b0;
        stall_i = 0; flush_i = 0; branch_flag_i = 0; new_pc_i = 0; branch_target_i = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_vals("boot_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].s, tbl[i].f, tbl[i].np, tbl[i].b, tbl[i].bt);
            chk({tag, ".ce"}, {31'b0, rom_ce_o}, 32'h1);
            chk({tag, ".addr"}, rom_addr_o, tbl[i].addr);
            chk({tag, ".id_pc"}, id_pc_o, tbl[i].idpc);
            chk({tag, ".id_inst"}, id_inst_o, tbl[i].v ? rom_word(tbl[i].idpc) : 32'h13);
            chk({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, tbl[i].v});
        end

        random_steps(300);

        // Asynchronous reset dropped between edges must take effect before the next edge.
        step(0, 0, 32'h0, 1, 32'h1234);
        step(0, 0, 32'h0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("async_hold");
        @(negedge clk);
        rst_n = 1'b1;

        random_steps(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage: owns the program counter and drives the chip-enable and address inputs of the instruction ROM. It captures the returned instruction into the IF/ID pipeline register for the decode stage. It handles pipeline stall, flush to an exception target, and branch redirect, including a branch that arrives while the pipeline is stalled. It sits between the pipeline control unit, the decode stage and `inst_rom`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall_i` input 1: from control; when 1, PC and IF/ID hold.
- `flush_i` input 1: from control; when 1, redirect to `new_pc_i`; highest priority.
- `new_pc_i` input `InstAddrBus`: flush target.
- `branch_flag_i` input 1: from decode; taken branch or jump.
- `branch_target_i` input `InstAddrBus`: branch target.
- `rom_ce_o` output 1: ROM chip enable, using `ChipEnable`/`ChipDisable`.
- `rom_addr_o` output `InstAddrBus`: fetch address; bits [1:0] are always 0.
- `rom_inst_i` input `InstBus`: ROM data, valid combinationally in the same cycle.
- `id_pc_o` output `InstAddrBus`: PC of the instruction held in IF/ID.
- `id_inst_o` output `InstBus`: instruction held in IF/ID.
- `id_valid_o` output 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- Two-state FSM.
  - BOOT is entered on reset. `rom_ce_o`=0. Moves to RUN on the first clock edge after `rst_n` deasserts.
  - RUN: `rom_ce_o`=1.
- Registers:
  - `pc`, which drives `rom_addr_o`.
  - `pend` (1 bit) and `pend_tgt`, which hold a deferred branch.
  - IF/ID: `id_pc_o`, `id_inst_o`, `id_valid_o`.
- Bubble value: `id_inst_o`=`NopInst` (32'h00000013), `id_valid_o`=0, `id_pc_o`=`ZeroWord`.
- Per-edge priority in RUN:
  1. **flush_i**: `pc`←{`new_pc_i`[31:2],2'b00}; IF/ID←bubble; `pend`←0. Ignores `stall_i`.
  2. **stall_i**: `pc` and IF/ID hold. If `branch_flag_i`=1, then `pend`←1 and `pend_tgt`←aligned `branch_target_i`.
  3. **pend**: `pc`←`pend_tgt`; IF/ID←bubble; `pend`←0.
  4. **branch_flag_i**: `pc`←aligned `branch_target_i`; IF/ID←bubble. The instruction fetched this cycle is wrong-path; there is no delay slot.
  5. **otherwise**: `pc`←`pc`+4; IF/ID←{`pc`, `rom_inst_i`, 1}.
- In BOOT, `pc` stays at `RESET_PC` and IF/ID stays at bubble.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values (asynchronous):
  - state=BOOT, `rom_ce_o`=0.
  - `pc`=`rom_addr_o`=`RESET_PC`.
  - `pend`=0, `pend_tgt`=0.
  - IF/ID = bubble.
- Reset asserted mid-operation returns every register to these values immediately, without waiting for a clock edge.
- First `rom_ce_o`=1: the cycle after the first edge with `rst_n`=1.
- First `id_valid_o`=1: one edge later, with `id_pc_o`=`RESET_PC`.
- Fetch-to-IF/ID latency is 1 cycle.
- Taken-branch penalty is 1 bubble.
- A branch during a stall costs 1 bubble after the stall releases.
- `rom_ce_o` is registered (driven from state). `rom_addr_o` is registered (driven from `pc`).
- If a deferred branch is pending and `branch_flag_i` is still asserted in the release cycle, `pend_tgt` is used and the outcome is identical.

## Structure
- Shared `define.v` holds:
  - existing: `InstAddrBus`, `InstBus`, `ChipEnable`, `ChipDisable`, `ZeroWord`;
  - new: `NopInst` and the state encodings `FetchBoot`/`FetchRun`.
- Sub-module `if_id_reg` holds the IF/ID register. It has load, hold and bubble controls plus the asynchronous active-low reset.
- `inst_fetch` contains the PC, the FSM and the pending-branch logic.

## Test plan
- **Reset/boot:** hold `rst_n`=0 for 3 cycles, then release.
  - Required: `rom_ce_o`=0 and `rom_addr_o`=0 until 1 edge after release, then `rom_ce_o`=1.
  - Then `id_pc_o` sequence 0, 4, 8, with `id_inst_o` equal to the ROM words 0x02000193, 0x04000213, 0x02118193.
- **Branch:** with `pc`=8, pulse `branch_flag_i`, target 0x40.
  - Required: next `rom_addr_o`=0x40 and IF/ID = bubble (0x13, valid 0).
  - Next edge: `id_pc_o`=0x40.
- **Stall + deferred branch:** assert `stall_i` for 3 cycles at `pc`=0x10, with `branch_flag_i` (target 0x80) in stall cycle 2.
  - Required: `pc`=0x10 and IF/ID frozen throughout the stall.
  - After release: `pc`=0x80 and one bubble.
- **Flush over stall:** `stall_i`=1, `flush_i`=1, `new_pc_i`=0x203, with a pending branch present.
  - Required: `pc`=0x200, `pend`=0, IF/ID = bubble.
- **Wrap:** branch to 0xFFFF_FFFC.
  - Required: the following fetch address is 0x0000_0000.
- **Async reset mid-run:** drop `rst_n` between clock edges.
  - Required: all outputs reach reset values within the same cycle, with no edge needed.
